// File: rtl/snake_pkg.sv
// Shared snake types: grid constants, direction codes, FSM states, {y,x} packing helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_pkg;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int XW      = 5;
    localparam int YW      = 5;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int START_X = 16;
    localparam int START_Y = 12;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CALC,
        ST_PUSH,
        ST_POP,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef logic [YW+XW-1:0] pos_t;

    function automatic pos_t pack_pos(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {y, x};
    endfunction

    function automatic logic [XW-1:0] pos_x(input pos_t p);
        return p[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] pos_y(input pos_t p);
        return p[XW+YW-1:XW];
    endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Next head cell one step along dir, wrapping at the grid edges.
// Latency: combinational.
// Backpressure: none.
module snake_next_pos #(
    parameter int GRID_W = snake_pkg::GRID_W,
    parameter int GRID_H = snake_pkg::GRID_H,
    parameter int XW     = snake_pkg::XW,
    parameter int YW     = snake_pkg::YW
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    dir,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y
);
    import snake_pkg::*;

    // Explicit edge compares rather than modulo, so non-power-of-2 grids wrap correctly.
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    always_comb begin
        next_x = x;
        next_y = y;
        case (dir)
            DIR_UP:   next_y = (y == '0)    ? Y_MAX : y - 1'b1;
            DIR_DOWN: next_y = (y == Y_MAX) ? '0    : y + 1'b1;
            DIR_LEFT: next_x = (x == '0)    ? X_MAX : x - 1'b1;
            default:  next_x = (x == X_MAX) ? '0    : x + 1'b1;
        endcase
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake move sequencer: per tick pushes the new head and pops the tail unless growing.
// Latency: push at T+2, pop at T+3, tail_valid at T+5 (grow path done at T+3).
// Backpressure: none; ticks arriving while busy are dropped, not queued.
module snake_move_ctrl #(
    parameter int GRID_W  = snake_pkg::GRID_W,
    parameter int GRID_H  = snake_pkg::GRID_H,
    parameter int XW      = snake_pkg::XW,
    parameter int YW      = snake_pkg::YW,
    parameter int MAX_LEN = snake_pkg::MAX_LEN,
    parameter int LEN_W   = snake_pkg::LEN_W,
    parameter int START_X = snake_pkg::START_X,
    parameter int START_Y = snake_pkg::START_Y
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          dir_in,
    input  logic                grow,
    input  logic [XW+YW-1:0]    pos_in,
    output logic                push,
    output logic                pop,
    output logic [XW+YW-1:0]    pos_out,
    output logic [XW-1:0]       head_x,
    output logic [YW-1:0]       head_y,
    output logic [XW+YW-1:0]    tail_pos,
    output logic                tail_valid,
    output logic [LEN_W-1:0]    length,
    output logic                busy
);
    import snake_pkg::*;

    localparam logic [XW-1:0]    START_XV  = XW'(START_X);
    localparam logic [YW-1:0]    START_YV  = YW'(START_Y);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t           state;
    logic [1:0]       cur_dir;
    logic             grow_pend;
    logic [XW-1:0]    next_x;
    logic [YW-1:0]    next_y;

    snake_next_pos #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_next_pos (
        .x      (head_x),
        .y      (head_y),
        .dir    (cur_dir),
        .next_x (next_x),
        .next_y (next_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            head_x     <= START_XV;
            head_y     <= START_YV;
            cur_dir    <= DIR_RIGHT;
            length     <= '0;
            push       <= 1'b0;
            pop        <= 1'b0;
            tail_valid <= 1'b0;
            tail_pos   <= '0;
            pos_out    <= '0;
            grow_pend  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            push       <= 1'b0;
            pop        <= 1'b0;
            tail_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    push    <= 1'b1;
                    pos_out <= {START_YV, START_XV};
                    length  <= LEN_W'(1);
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (tick) begin
                        // A U-turn would run the head into its own neck; keep heading.
                        if ((dir_in ^ cur_dir) != 2'd2) begin
                            cur_dir <= dir_in;
                        end
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    push    <= 1'b1;
                    pos_out <= {next_y, next_x};
                    state   <= ST_PUSH;
                end
                ST_PUSH: begin
                    head_x    <= pos_out[XW-1:0];
                    head_y    <= pos_out[XW+YW-1:XW];
                    grow_pend <= 1'b0;
                    if (grow_pend && (length < MAX_LEN_V)) begin
                        length <= length + 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        pop   <= 1'b1;
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    tail_pos   <= pos_in;
                    tail_valid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
            // Placed after the case so a grow landing on the PUSH cycle survives the clear.
            if (grow) begin
                grow_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench: timeline model of a move plus a FIFO stand-in for the body stack.
module tb_snake_move_ctrl;
    import snake_pkg::*;

    localparam int PW = XW + YW;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [1:0]       dir_in;
    logic             grow;
    logic [PW-1:0]    pos_in;
    logic             push;
    logic             pop;
    logic [PW-1:0]    pos_out;
    logic [XW-1:0]    head_x;
    logic [YW-1:0]    head_y;
    logic [PW-1:0]    tail_pos;
    logic             tail_valid;
    logic [LEN_W-1:0] length;
    logic             busy;

    always #5 clk = ~clk;

    snake_move_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .dir_in     (dir_in),
        .grow       (grow),
        .pos_in     (pos_in),
        .push       (push),
        .pop        (pop),
        .pos_out    (pos_out),
        .head_x     (head_x),
        .head_y     (head_y),
        .tail_pos   (tail_pos),
        .tail_valid (tail_valid),
        .length     (length),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since an accepted tick (-2 INIT, -1 idle).
    bit            m_valid = 1'b0;
    int            m_age;
    int            m_x, m_y, m_dir, m_len, m_nx, m_ny;
    bit            m_gp, m_grow_mv;
    bit            e_push, e_pop, e_tv, e_busy;
    logic [PW-1:0] e_pos, e_tail;
    int            m_body[$];

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_age   = -2;
            m_x     = START_X;
            m_y     = START_Y;
            m_dir   = 1;
            m_len   = 0;
            m_gp    = 1'b0;
            e_push  = 1'b0;
            e_pop   = 1'b0;
            e_tv    = 1'b0;
            e_busy  = 1'b1;
            e_pos   = '0;
            e_tail  = '0;
            m_body.delete();
        end else if (m_valid) begin
            e_push = 1'b0;
            e_pop  = 1'b0;
            e_tv   = 1'b0;
            if (m_age == -2) begin
                e_push = 1'b1;
                e_pos  = pack_pos(XW'(START_X), YW'(START_Y));
                m_len  = 1;
                e_busy = 1'b0;
                m_body.push_back(int'(e_pos));
                m_age  = -1;
            end else if (m_age == -1) begin
                if (tick) begin
                    if (int'(dir_in) != (m_dir + 2) % 4) m_dir = int'(dir_in);
                    e_busy = 1'b1;
                    m_age  = 1;
                end
            end else begin
                case (m_age)
                    1: begin
                        m_nx = m_x;
                        m_ny = m_y;
                        case (m_dir)
                            0: m_ny = (m_y + GRID_H - 1) % GRID_H;
                            1: m_nx = (m_x + 1) % GRID_W;
                            2: m_ny = (m_y + 1) % GRID_H;
                            default: m_nx = (m_x + GRID_W - 1) % GRID_W;
                        endcase
                        e_push = 1'b1;
                        e_pos  = pack_pos(XW'(m_nx), YW'(m_ny));
                    end
                    2: begin
                        m_x = m_nx;
                        m_y = m_ny;
                        m_body.push_back(int'(e_pos));
                        m_grow_mv = m_gp && (m_len < MAX_LEN);
                        m_gp = 1'b0;
                        if (m_grow_mv) m_len++;
                        else e_pop = 1'b1;
                    end
                    3: if (m_grow_mv) e_busy = 1'b0;
                    4: begin
                        e_tail = PW'(m_body.pop_front());
                        e_tv   = 1'b1;
                    end
                    default: e_busy = 1'b0;
                endcase
                if (!e_busy) m_age = -1;
                else m_age++;
            end
            if (grow) m_gp = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("push", push, e_push);
            check("pop", pop, e_pop);
            check("pos_out", pos_out, e_pos);
            check("head_x", head_x, m_x);
            check("head_y", head_y, m_y);
            check("tail_pos", tail_pos, e_tail);
            check("tail_valid", tail_valid, e_tv);
            check("length", length, m_len);
            check("busy", busy, e_busy);
        end
    end

    // Stack stand-in: returns the oldest pushed cell one cycle after a pop.
    int            stk[$];
    bit            stk_pend = 1'b0;
    int            n_push = 0, n_pop = 0, n_tv = 0;
    logic [PW-1:0] last_push = '0;
    logic [PW-1:0] last_tail = '0;

    always @(negedge clk) begin
        if (reset) begin
            stk.delete();
            stk_pend = 1'b0;
        end else begin
            if (push) begin
                stk.push_back(int'(pos_out));
                n_push++;
                last_push = pos_out;
            end
            if (pop) begin
                stk_pend = 1'b1;
                n_pop++;
            end
            if (tail_valid) begin
                n_tv++;
                last_tail = tail_pos;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stk_pend && stk.size() > 0) pos_in = PW'(stk.pop_front());
        else pos_in = PW'($urandom);
        stk_pend = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [1:0] d, input bit g);
        step();
        tick   = 1'b1;
        dir_in = d;
        grow   = g;
        step();
        tick = 1'b0;
        grow = 1'b0;
        repeat (6) step();
    endtask

    int p0, p1;
    logic [PW-1:0] lp;

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        grow   = 1'b0;
        dir_in = 2'd1;
        pos_in = '0;
        repeat (3) step();
        reset = 1'b0;

        @(negedge clk);
        check("init_cycle_push", push, 1'b0);
        check("init_cycle_busy", busy, 1'b1);
        @(negedge clk);
        check("init_push", push, 1'b1);
        check("init_pos", pos_out, 32'h190);
        check("init_len", length, 1);
        check("init_busy", busy, 1'b0);

        move(2'd1, 1'b0);
        check("straight_push", last_push, 32'h191);
        check("straight_tail", last_tail, 32'h190);
        check("straight_len", length, 1);

        move(2'd3, 1'b0);
        check("reverse_push", last_push, 32'h192);
        check("reverse_head_x", head_x, 18);

        p0 = n_push;
        step();
        tick   = 1'b1;
        dir_in = 2'd1;
        step();
        step();
        tick = 1'b0;
        repeat (6) step();
        check("busy_tick_pushes", n_push - p0, 1);

        p0 = n_pop;
        p1 = n_tv;
        step();
        grow = 1'b1;
        step();
        grow = 1'b0;
        move(2'd1, 1'b0);
        check("grow_pops", n_pop - p0, 0);
        check("grow_tail_valids", n_tv - p1, 0);
        check("grow_len", length, 2);

        repeat (11) move(2'd1, 1'b0);
        repeat (7) move(2'd0, 1'b0);
        check("pre_wrap_x", head_x, 31);
        check("pre_wrap_y", head_y, 5);
        move(2'd1, 1'b0);
        lp = last_push;
        check("wrap_right_x", lp[XW-1:0], 0);
        repeat (3) move(2'd1, 1'b0);
        repeat (5) move(2'd0, 1'b0);
        move(2'd0, 1'b0);
        lp = last_push;
        check("wrap_up_y", lp[PW-1:XW], 23);
        check("wrap_up_x", lp[XW-1:0], 3);

        for (int k = 0; k < 100 && m_len < MAX_LEN; k++) move(2'(m_dir), 1'b1);
        p0 = n_pop;
        move(2'(m_dir), 1'b1);
        check("full_pops", n_pop - p0, 1);
        check("full_len", length, 64);

        step();
        tick   = 1'b1;
        dir_in = 2'(m_dir);
        step();
        tick = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("abort_pop_before", pop, 1'b1);
        @(negedge clk);
        check("abort_pop_after", pop, 1'b0);
        check("abort_len", length, 0);
        check("abort_head_x", head_x, 16);
        check("abort_head_y", head_y, 12);
        step();
        reset = 1'b0;
        repeat (3) step();

        for (int c = 0; c < 2500; c++) begin
            step();
            tick   = ($urandom % 5) == 0;
            dir_in = 2'($urandom);
            grow   = ($urandom % 10) == 0;
            reset  = ($urandom % 400) == 0;
        end
        tick  = 1'b0;
        grow  = 1'b0;
        reset = 1'b0;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
